// File: rtl/vga_mem_arbiter.sv
// Single-port pixel memory arbiter: the display fetch path has absolute priority,
// and the host port uses valid/ready. Read data returns two clocks after issue.
module vga_mem_arbiter #(
    parameter int unsigned ADDR_W       = 11,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned STARVE_LIMIT = 1600,
    parameter int unsigned CNT_W        = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_data,
    input  logic              host_valid,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ready,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_starved,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_DISP = 2'd1,
        TAG_HOST = 2'd2
    } tag_e;

    tag_e              issue_tag;
    tag_e              tag1_q, tag1_d;
    tag_e              tag2_q, tag2_d;
    logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;
    logic [DATA_W-1:0] disp_data_q, disp_data_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              starved_q, starved_d;

    // Grant is combinational; the rst_n gate forces every output to 0 during reset.
    always_comb begin
        issue_tag  = TAG_NONE;
        host_ready = 1'b0;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        mem_addr   = addr_hold_q;
        if (!rst_n) begin
            mem_addr = '0;
        end else if (disp_req) begin
            mem_addr  = disp_addr;
            issue_tag = TAG_DISP;
        end else if (host_valid) begin
            host_ready = 1'b1;
            mem_addr   = host_addr;
            mem_we     = host_we;
            mem_wdata  = host_wdata;
            issue_tag  = host_we ? TAG_NONE : TAG_HOST;
        end
    end

    always_comb begin
        addr_hold_d  = mem_addr;
        tag1_d       = issue_tag;
        tag2_d       = tag1_q;
        disp_data_d  = disp_data_q;
        host_rdata_d = host_rdata_q;
        if (tag1_q == TAG_DISP) disp_data_d = mem_rdata;
        if (tag1_q == TAG_HOST) host_rdata_d = mem_rdata;

        stall_cnt_d = '0;
        if (host_valid && !host_ready)
            stall_cnt_d = (stall_cnt_q == '1) ? stall_cnt_q : stall_cnt_q + 1'b1;
        starved_d = (stall_cnt_q >= CNT_W'(STARVE_LIMIT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag1_q       <= TAG_NONE;
            tag2_q       <= TAG_NONE;
            addr_hold_q  <= '0;
            disp_data_q  <= '0;
            host_rdata_q <= '0;
            stall_cnt_q  <= '0;
            starved_q    <= 1'b0;
        end else begin
            tag1_q       <= tag1_d;
            tag2_q       <= tag2_d;
            addr_hold_q  <= addr_hold_d;
            disp_data_q  <= disp_data_d;
            host_rdata_q <= host_rdata_d;
            stall_cnt_q  <= stall_cnt_d;
            starved_q    <= starved_d;
        end
    end

    assign disp_valid   = (tag2_q == TAG_DISP);
    assign host_rvalid  = (tag2_q == TAG_HOST);
    assign disp_data    = disp_data_q;
    assign host_rdata   = host_rdata_q;
    assign stall_cnt    = stall_cnt_q;
    assign host_starved = starved_q;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Directed bench for vga_mem_arbiter with a write-first synchronous memory model
// and a second small-counter instance for saturation.
module tb_vga_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        disp_req;
    logic [10:0] disp_addr;
    logic        host_valid;
    logic        host_we;
    logic [10:0] host_addr;
    logic [7:0]  host_wdata;

    logic        disp_valid, host_ready, host_rvalid, host_starved, mem_we;
    logic [7:0]  disp_data, host_rdata, mem_wdata, mem_rdata;
    logic [11:0] stall_cnt;
    logic [10:0] mem_addr;

    logic        s_disp_valid, s_host_ready, s_host_rvalid, s_host_starved, s_mem_we;
    logic [7:0]  s_disp_data, s_host_rdata, s_mem_wdata;
    logic [3:0]  s_stall_cnt;
    logic [10:0] s_mem_addr;

    logic [7:0]  mem [0:2047];

    int unsigned passed = 0;
    int unsigned total  = 0;

    always #5 clk = ~clk;

    vga_mem_arbiter #(.ADDR_W(11), .DATA_W(8), .STARVE_LIMIT(1600), .CNT_W(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_valid(disp_valid), .disp_data(disp_data),
        .host_valid(host_valid), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ready(host_ready), .host_rvalid(host_rvalid),
        .host_rdata(host_rdata), .host_starved(host_starved), .stall_cnt(stall_cnt),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    vga_mem_arbiter #(.ADDR_W(11), .DATA_W(8), .STARVE_LIMIT(10), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_valid(s_disp_valid), .disp_data(s_disp_data),
        .host_valid(host_valid), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ready(s_host_ready), .host_rvalid(s_host_rvalid),
        .host_rdata(s_host_rdata), .host_starved(s_host_starved), .stall_cnt(s_stall_cnt),
        .mem_addr(s_mem_addr), .mem_we(s_mem_we), .mem_wdata(s_mem_wdata), .mem_rdata(mem_rdata)
    );

    initial for (int i = 0; i < 2048; i++) mem[i] = i[7:0];

    // Write-first registered memory
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            mem_rdata     <= mem_wdata;
        end else begin
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_disp_valid"}, 32'(disp_valid), 0);
        chk({tag, "_disp_data"}, 32'(disp_data), 0);
        chk({tag, "_host_ready"}, 32'(host_ready), 0);
        chk({tag, "_host_rvalid"}, 32'(host_rvalid), 0);
        chk({tag, "_host_rdata"}, 32'(host_rdata), 0);
        chk({tag, "_starved"}, 32'(host_starved), 0);
        chk({tag, "_stall_cnt"}, 32'(stall_cnt), 0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
        chk({tag, "_mem_we"}, 32'(mem_we), 0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
    endtask

    initial begin
        // Reset with busy-looking inputs: every output must read 0
        rst_n = 1'b0; disp_req = 1'b1; disp_addr = 11'h123;
        host_valid = 1'b1; host_we = 1'b1; host_addr = 11'h456; host_wdata = 8'hFF;
        #1;
        chk_all_zero("reset");
        tick(); tick();
        chk_all_zero("reset_clk");
        disp_req = 1'b0; host_valid = 1'b0; host_we = 1'b0;
        rst_n = 1'b1;
        tick();

        // Display burst 0..639 with a host read pending the whole time
        disp_req = 1'b1; disp_addr = 11'd0;
        host_valid = 1'b1; host_we = 1'b0; host_addr = 11'h7FF;
        #1;
        chk("burst_ready0", 32'(host_ready), 0);
        for (int i = 1; i <= 643; i++) begin
            tick();
            chk("burst_disp_valid", 32'(disp_valid), 32'((i >= 2 && i <= 641) ? 1 : 0));
            if (i >= 2 && i <= 641) chk("burst_disp_data", 32'(disp_data), 32'((i - 2) % 256));
            chk("burst_host_rvalid", 32'(host_rvalid), 0);
            if (i < 640) begin
                disp_addr = 11'(i);
                #1;
                chk("burst_host_ready", 32'(host_ready), 0);
                chk("burst_mem_we", 32'(mem_we), 0);
                chk("burst_mem_addr", 32'(mem_addr), 32'(i));
            end else begin
                disp_req = 1'b0; host_valid = 1'b0;
            end
        end

        // Host write 0x155 <= 0xA5, then read it back
        host_valid = 1'b1; host_we = 1'b1; host_addr = 11'h155; host_wdata = 8'hA5;
        #1;
        chk("wr_ready", 32'(host_ready), 1);
        chk("wr_mem_we", 32'(mem_we), 1);
        chk("wr_mem_addr", 32'(mem_addr), 32'h155);
        chk("wr_mem_wdata", 32'(mem_wdata), 32'hA5);
        tick();
        host_we = 1'b0;
        #1;
        chk("rd_ready", 32'(host_ready), 1);
        chk("rd_mem_we", 32'(mem_we), 0);
        tick();
        host_valid = 1'b0;
        #1;
        chk("idle_ready", 32'(host_ready), 0);
        chk("idle_mem_we", 32'(mem_we), 0);
        chk("idle_addr_hold", 32'(mem_addr), 32'h155);
        chk("rd_rvalid_early", 32'(host_rvalid), 0);
        tick();
        chk("rd_rvalid", 32'(host_rvalid), 1);
        chk("rd_rdata", 32'(host_rdata), 32'hA5);
        tick();
        chk("rd_rvalid_pulse", 32'(host_rvalid), 0);
        chk("rd_rdata_hold", 32'(host_rdata), 32'hA5);
        chk("disp_data_hold", 32'(disp_data), 32'h7F);

        // Interleave: disp 1,0,1,0 with a host read of 0x010 pending throughout
        host_valid = 1'b1; host_we = 1'b0; host_addr = 11'h010;
        disp_req = 1'b1; disp_addr = 11'h020;
        #1; chk("il_c1_ready", 32'(host_ready), 0);
        tick(); chk("il_e1_dv", 32'(disp_valid), 0); chk("il_e1_hv", 32'(host_rvalid), 0);
        disp_req = 1'b0;
        #1; chk("il_c2_ready", 32'(host_ready), 1); chk("il_c2_addr", 32'(mem_addr), 32'h010);
        tick(); chk("il_e2_dv", 32'(disp_valid), 1); chk("il_e2_dd", 32'(disp_data), 32'h20);
        chk("il_e2_hv", 32'(host_rvalid), 0);
        disp_req = 1'b1; disp_addr = 11'h030;
        #1; chk("il_c3_ready", 32'(host_ready), 0); chk("il_c3_addr", 32'(mem_addr), 32'h030);
        tick(); chk("il_e3_dv", 32'(disp_valid), 0); chk("il_e3_hv", 32'(host_rvalid), 1);
        chk("il_e3_hd", 32'(host_rdata), 32'h10);
        disp_req = 1'b0;
        #1; chk("il_c4_ready", 32'(host_ready), 1);
        tick(); chk("il_e4_dv", 32'(disp_valid), 1); chk("il_e4_dd", 32'(disp_data), 32'h30);
        chk("il_e4_hv", 32'(host_rvalid), 0);
        host_valid = 1'b0;
        tick(); chk("il_e5_dv", 32'(disp_valid), 0); chk("il_e5_hv", 32'(host_rvalid), 1);
        chk("il_e5_hd", 32'(host_rdata), 32'h10);
        tick(); chk("il_e6_dv", 32'(disp_valid), 0); chk("il_e6_hv", 32'(host_rvalid), 0);

        // Starvation: host read of 0x155 blocked for 2000 cycles; small instance saturates
        disp_req = 1'b1; disp_addr = 11'h000;
        host_valid = 1'b1; host_we = 1'b0; host_addr = 11'h155;
        for (int i = 1; i <= 2000; i++) begin
            tick();
            if (i == 1 || i == 1599 || i == 1600 || i == 1601 || i == 2000) begin
                chk("st_cnt", 32'(stall_cnt), 32'(i));
                chk("st_starved", 32'(host_starved), 32'((i >= 1601) ? 1 : 0));
            end
            if (i == 9 || i == 10 || i == 11 || i == 15 || i == 16 || i == 40 || i == 2000) begin
                chk("sat_cnt", 32'(s_stall_cnt), 32'((i < 15) ? i : 15));
                chk("sat_starved", 32'(s_host_starved), 32'((i >= 11) ? 1 : 0));
            end
        end
        disp_req = 1'b0;
        #1; chk("st_accept_ready", 32'(host_ready), 1);
        tick();
        chk("st_cnt_clear", 32'(stall_cnt), 0);
        host_valid = 1'b0;
        tick();
        chk("st_starved_clear", 32'(host_starved), 0);
        chk("st_cnt_zero", 32'(stall_cnt), 0);
        chk("st_rvalid", 32'(host_rvalid), 1);
        chk("st_rdata", 32'(host_rdata), 32'hA5);
        chk("st_sat_clear", 32'(s_stall_cnt), 0);
        tick();

        // Reset mid-read: the accepted read must never respond
        host_valid = 1'b1; host_we = 1'b0; host_addr = 11'h010;
        #1; chk("rr_ready", 32'(host_ready), 1);
        tick();
        rst_n = 1'b0; host_we = 1'b1; host_wdata = 8'hFF;
        #1;
        chk_all_zero("rr_in_reset");
        tick();
        chk_all_zero("rr_in_reset_clk");
        rst_n = 1'b1; host_valid = 1'b0; host_we = 1'b0;
        tick(); chk("rr_no_rvalid1", 32'(host_rvalid), 0); chk("rr_addr0", 32'(mem_addr), 0);
        tick(); chk("rr_no_rvalid2", 32'(host_rvalid), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
